lsu_mem_master: RTL and testbench

- Initiator side of the data-memory port: the load/store unit between the core datapath and data_mem.
- Accepts one load/store request at a time over a valid/ready handshake and drives MemRead/MemWrite/addr/write_data.
- Performs byte-lane extraction with sign/zero extension for loads, and read-modify-write for SB/SH, because data_mem only writes full words.
- Returns a single-cycle response pulse carrying the load data or an error flag.

---
 rtl/lsu_pkg.sv | 56 +++++
 rtl/lsu_mem_master_if.sv | 32 +++
 rtl/lsu_align.sv | 14 +
 rtl/lsu_mem_master.sv | 147 ++++++++++++++
 tb/tb_lsu_mem_master.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit: funct3 encodings,
// FSM states, and the byte/halfword extract and merge functions.
package lsu_pkg;

    localparam int LSU_XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } lsu_state_t;

    function automatic logic [LSU_XLEN-1:0] lane_extract(
        input logic [LSU_XLEN-1:0] word,
        input logic [1:0]          off,
        input logic [2:0]          funct3
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    lane_extract = {{24{b[7]}}, b};
            F3_BU:   lane_extract = {24'b0, b};
            F3_H:    lane_extract = {{16{h[15]}}, h};
            F3_HU:   lane_extract = {16'b0, h};
            default: lane_extract = word;
        endcase
    endfunction

    // Only the low two funct3 bits matter here: stores never carry the unsigned bit.
    function automatic logic [LSU_XLEN-1:0] lane_merge(
        input logic [LSU_XLEN-1:0] old,
        input logic [LSU_XLEN-1:0] wdata,
        input logic [1:0]          off,
        input logic [2:0]          funct3
    );
        logic [LSU_XLEN-1:0] m;
        m = old;
        case (funct3[1:0])
            2'b00:   m[{off, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   m[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: m = wdata;
        endcase
        lane_merge = m;
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response handshake plus the data_mem strobe bus of the LSU.
// master = the LSU itself; slave = the core/memory side driving it.
interface lsu_mem_master_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;
    logic            MemRead;
    logic            MemWrite;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] read_data;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               MemRead, MemWrite, addr, write_data
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               MemRead, MemWrite, addr, write_data
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension and SB/SH word merge.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [LSU_XLEN-1:0] rd_word_i,
    input  logic [LSU_XLEN-1:0] wdata_i,
    input  logic [1:0]          off_i,
    input  logic [2:0]          funct3_i,
    output logic [LSU_XLEN-1:0] ext_o,
    output logic [LSU_XLEN-1:0] merged_o
);
    assign ext_o    = lane_extract(rd_word_i, off_i, funct3_i);
    assign merged_o = lane_merge(rd_word_i, wdata_i, off_i, funct3_i);
endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit master port to data_mem: one request at a time, RMW for SB/SH.
// Optional LSU_STATS_EN adds saturating load/store/error counters.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_mem_master_if.master  bus
`ifdef LSU_STATS_EN
    ,
    output logic [15:0]       stat_loads,
    output logic [15:0]       stat_stores,
    output logic [15:0]       stat_errs
`endif
);

    lsu_state_t      state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] wword_q, wword_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            f3_ok, align_ok, illegal;
    logic [XLEN-1:0] ext, merged;

    lsu_align u_align (
        .rd_word_i (bus.read_data),
        .wdata_i   (wdata_q),
        .off_i     (addr_q[1:0]),
        .funct3_i  (funct3_q),
        .ext_o     (ext),
        .merged_o  (merged)
    );

    // Unsigned funct3 codes are load-only; anything else unlisted is illegal.
    always_comb begin
        f3_ok    = 1'b0;
        align_ok = 1'b1;
        case (bus.req_funct3)
            F3_B:    f3_ok = 1'b1;
            F3_H:    begin f3_ok = 1'b1;         align_ok = ~bus.req_addr[0]; end
            F3_W:    begin f3_ok = 1'b1;         align_ok = (bus.req_addr[1:0] == 2'b00); end
            F3_BU:   f3_ok = ~bus.req_we;
            F3_HU:   begin f3_ok = ~bus.req_we;  align_ok = ~bus.req_addr[0]; end
            default: f3_ok = 1'b0;
        endcase
        illegal = ~f3_ok | ~align_ok | (bus.req_addr >= XLEN'(MEM_BYTES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wword_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wword_q  <= wword_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wword_d  = wword_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    rdata_d  = '0;
                    err_d    = illegal;
                    if (bus.req_we) wword_d = bus.req_wdata;
                    if (illegal)                      state_d = S_RESP;
                    else if (!bus.req_we)             state_d = S_READ;
                    else if (bus.req_funct3 == F3_W)  state_d = S_WRITE;
                    else                              state_d = S_RMW_RD;
                end
            end
            S_READ: begin
                rdata_d = ext;
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                wword_d = merged;
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode registered state only, so they cannot glitch within a cycle.
    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_err   = err_q & (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.MemRead    = (state_q == S_READ) | (state_q == S_RMW_RD);
    assign bus.MemWrite   = (state_q == S_WRITE) & we_q;
    assign bus.addr       = {addr_q[XLEN-1:2], 2'b00};
    assign bus.write_data = wword_q;

`ifdef LSU_STATS_EN
    logic [15:0] ld_cnt_q, st_cnt_q, er_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
            er_cnt_q <= '0;
        end else if (state_q == S_RESP) begin
            if (err_q)     er_cnt_q <= er_cnt_q + {15'b0, er_cnt_q != 16'hFFFF};
            else if (we_q) st_cnt_q <= st_cnt_q + {15'b0, st_cnt_q != 16'hFFFF};
            else           ld_cnt_q <= ld_cnt_q + {15'b0, ld_cnt_q != 16'hFFFF};
        end
    end

    assign stat_loads  = ld_cnt_q;
    assign stat_stores = st_cnt_q;
    assign stat_errs   = er_cnt_q;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized self-checking bench for lsu_mem_master against a word-array
// memory model and a size/offset arithmetic reference.
module tb_lsu_mem_master;

    localparam int MEM_BYTES = 1024;
    localparam int MEM_WORDS = MEM_BYTES / 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fill = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_master_if #(.XLEN(32)) bus ();

`ifdef LSU_STATS_EN
    logic [15:0] stat_loads, stat_stores, stat_errs;
`endif

    lsu_mem_master #(.XLEN(32), .MEM_BYTES(MEM_BYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
`ifdef LSU_STATS_EN
        ,
        .stat_loads  (stat_loads),
        .stat_stores (stat_stores),
        .stat_errs   (stat_errs)
`endif
    );

    // data_mem stand-in: combinational read, full-word write on the clock edge
    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    assign bus.read_data = mem[bus.addr[9:2]];

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= ref_mem[i];
        end else if (bus.MemWrite) begin
            mem[bus.addr[9:2]] <= bus.write_data;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: legality, latency, strobe counts and data from size/offset arithmetic.
    function automatic void model(
        input  bit        we,
        input  bit [2:0]  f3,
        input  bit [31:0] a,
        input  bit [31:0] wd,
        output bit        err,
        output bit [31:0] rd,
        output int        lat,
        output int        nrd,
        output int        nwr,
        output bit [31:0] wword
    );
        int        sz, sh;
        bit        ok;
        bit [31:0] old, mask, v;
        ok    = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        sz    = 1 << f3[1:0];
        rd    = 0;
        wword = 0;
        if (!ok || a >= MEM_BYTES || (a % sz) != 0) begin
            err = 1; lat = 1; nrd = 0; nwr = 0;
            return;
        end
        err  = 0;
        old  = ref_mem[a / 4];
        sh   = (a % 4) * 8;
        mask = (sz == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * sz)) - 1);
        if (!we) begin
            v = (old >> sh) & mask;
            if (f3 <= 3'd1 && v[8 * sz - 1]) v = v | ~mask;
            rd = v; lat = 2; nrd = 1; nwr = 0;
        end else begin
            v = (old & ~(mask << sh)) | ((wd & mask) << sh);
            ref_mem[a / 4] = v;
            wword = v; nwr = 1;
            nrd = (sz == 4) ? 0 : 1;
            lat = (sz == 4) ? 2 : 3;
        end
    endfunction

    task automatic run(input string tag, input bit we, input bit [2:0] f3,
                       input bit [31:0] a, input bit [31:0] wd);
        bit        e_err, got_err, done;
        bit [31:0] e_rd, e_ww, got_rd, wa, wdat;
        int        e_lat, e_nrd, e_nwr, lat, nrd, nwr, both, w;
        model(we, f3, a, wd, e_err, e_rd, e_lat, e_nrd, e_nwr, e_ww);
        @(negedge clk);
        chk({tag, ".idle_rv"}, 32'(bus.resp_valid), 32'd0);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        w = 0;
        while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
        chk({tag, ".rdy"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; both = 0; done = 0;
        wa = 0; wdat = 0; got_err = 0; got_rd = 0;
        while (!done && lat < 8) begin
            @(negedge clk);
            lat++;
            if (bus.MemRead) nrd++;
            if (bus.MemWrite) begin nwr++; wa = bus.addr; wdat = bus.write_data; end
            if (bus.MemRead && bus.MemWrite) both++;
            if (bus.resp_valid) begin done = 1; got_err = bus.resp_err; got_rd = bus.resp_rdata; end
        end
        chk({tag, ".lat"},   32'(lat),     32'(e_lat));
        chk({tag, ".err"},   32'(got_err), 32'(e_err));
        chk({tag, ".rdata"}, got_rd,       e_rd);
        chk({tag, ".nrd"},   32'(nrd),     32'(e_nrd));
        chk({tag, ".nwr"},   32'(nwr),     32'(e_nwr));
        chk({tag, ".both"},  32'(both),    32'd0);
        if (e_nwr != 0) begin
            chk({tag, ".waddr"}, wa,   a & ~32'd3);
            chk({tag, ".wdata"}, wdat, e_ww);
        end
    endtask

    bit [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        bit        qwe  [4];
        bit [2:0]  qf3  [4];
        bit [31:0] qa   [4];
        bit [31:0] qwd  [4];
        bit        eerr [4];
        bit [31:0] erd  [4];
        bit [31:0] dww;
        bit [31:0] got_rd [$];
        bit        got_err [$];
        int        elat_sum, busy, nwr, dl, dr, dw, sz;
        bit        rwe;
        bit [2:0]  rf3;
        bit [31:0] ra;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = $urandom;

        // reset held 3 cycles; memory image loaded meanwhile
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        fill = 1'b0;
        chk("rst.ready",  32'(bus.req_ready),  32'd1);
        chk("rst.memrd",  32'(bus.MemRead),    32'd0);
        chk("rst.memwr",  32'(bus.MemWrite),   32'd0);
        chk("rst.rvalid", 32'(bus.resp_valid), 32'd0);
        chk("rst.rerr",   32'(bus.resp_err),   32'd0);
        chk("rst.addr",   bus.addr,            32'd0);
        chk("rst.wdata",  bus.write_data,      32'd0);
        chk("rst.rdata",  bus.resp_rdata,      32'd0);
        rst_n = 1'b1;

        run("sw_dead", 1, 3'b010, 32'h10, 32'hDEADBEEF);
        run("sw_ext",  1, 3'b010, 32'h10, 32'h80FF7F01);
        run("lb12",    0, 3'b000, 32'h12, 0);
        run("lbu12",   0, 3'b100, 32'h12, 0);
        run("lh12",    0, 3'b001, 32'h12, 0);
        run("lw10",    0, 3'b010, 32'h10, 0);

        run("sw20",    1, 3'b010, 32'h20, 32'h11223344);
        run("sb21",    1, 3'b000, 32'h21, 32'h000000AA);
        run("lw20",    0, 3'b010, 32'h20, 0);

        run("e_lw06",  0, 3'b010, 32'h06, 0);
        run("e_sh03",  1, 3'b001, 32'h03, 32'h1234);
        run("e_lwmax", 0, 3'b010, 32'(MEM_BYTES), 0);
        run("e_f3_3",  0, 3'b011, 32'h40, 0);
        run("e_sbu",   1, 3'b100, 32'h40, 32'h55);

        // back-to-back with req_valid held high
        qwe = '{0, 1, 0, 0};
        qf3 = '{3'b010, 3'b000, 3'b100, 3'b010};
        qa  = '{32'h10, 32'h22, 32'h22, 32'h07};
        qwd = '{0, 32'h5A, 0, 0};
        elat_sum = 0;
        for (int i = 0; i < 4; i++) begin
            model(qwe[i], qf3[i], qa[i], qwd[i], eerr[i], erd[i], dl, dr, dw, dww);
            elat_sum += dl;
        end
        busy = 0;
        fork
            begin
                int w;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    bus.req_valid = 1'b1; bus.req_we = qwe[i]; bus.req_funct3 = qf3[i];
                    bus.req_addr = qa[i]; bus.req_wdata = qwd[i];
                    w = 0;
                    while (!bus.req_ready && w < 20) begin @(negedge clk); w++; end
                    @(posedge clk);
                end
                #1 bus.req_valid = 1'b0;
            end
            begin
                int c;
                c = 0;
                while (got_rd.size() < 4 && c < 80) begin
                    @(negedge clk);
                    c++;
                    if (!bus.req_ready) busy++;
                    if (bus.resp_valid) begin
                        got_rd.push_back(bus.resp_rdata);
                        got_err.push_back(bus.resp_err);
                    end
                end
            end
        join
        chk("b2b.count", 32'(got_rd.size()), 32'd4);
        chk("b2b.busy",  32'(busy),          32'(elat_sum));
        for (int i = 0; i < 4 && i < got_rd.size(); i++) begin
            chk($sformatf("b2b.rd%0d", i),  got_rd[i],        erd[i]);
            chk($sformatf("b2b.err%0d", i), 32'(got_err[i]), 32'(eerr[i]));
        end

        // reset in the middle of an SH read-modify-write
        run("sw30", 1, 3'b010, 32'h30, 32'hCAFEF00D);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b001;
        bus.req_addr = 32'h30; bus.req_wdata = 32'h1234;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("mid.rmwrd", 32'(bus.MemRead), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid.rst_rd", 32'(bus.MemRead), 32'd0);
        nwr = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.MemWrite) nwr++;
        end
        chk("mid.nwr", 32'(nwr), 32'd0);
        chk("mid.rdy", 32'(bus.req_ready), 32'd1);
        rst_n = 1'b1;
        run("lw30", 0, 3'b010, 32'h30, 0);

        // randomized traffic over a small window so loads observe earlier stores
        for (int i = 0; i < 60; i++) begin
            rwe = 1'($urandom % 2);
            if ($urandom % 6 == 0) rf3 = 3'($urandom);
            else if (rwe)          rf3 = 3'($urandom % 3);
            else                   rf3 = ld_f3[$urandom % 5];
            if ($urandom % 10 == 0) ra = 32'(MEM_BYTES + $urandom % 64);
            else                    ra = 32'h100 + 32'($urandom % 64);
            sz = 1 << rf3[1:0];
            if ($urandom % 4 != 0) ra = ra & ~32'(sz - 1);
            run($sformatf("rnd%0d", i), rwe, rf3, ra, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
